// File: rtl/tankb_rom_loader_if.sv
// tankb_rom_loader_if: HPS ioctl download bus between hps_io (master) and the ROM loader (slave).
interface tankb_rom_loader_if;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  modport master (output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, input ioctl_wait);
  modport slave (input ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, output ioctl_wait);
endinterface

// File: rtl/tankb_rom_loader.sv
// tankb_rom_loader: owns the shared ROM/PROM write port, sequences index-0 downloads and holds the game in reset.
// Optional TANKB_DL_CHECKSUM_EN adds dl_sum/dl_done download checksum outputs.
module tankb_rom_loader #(
  parameter logic [13:0] PROG_END    = 14'h1FFF,
  parameter logic [13:0] GFX_END     = 14'h27FF,
  parameter logic [13:0] PROM_END    = 14'h281F,
  parameter int          WR_CYCLES   = 2,
  parameter int          HOLD_CYCLES = 16
) (
  input  logic                CLK_18M,
  input  logic                RESET_n,
  tankb_rom_loader_if.slave   io,
  input  logic [13:0]         cpu_addr,
  output logic [7:0]          cpu_dout,
  output logic [13:0]         mem_addr,
  output logic [7:0]          mem_din,
  input  logic [7:0]          mem_dout,
  output logic                we_prog,
  output logic                we_gfx,
  output logic                we_prom,
  output logic                core_reset_n
`ifdef TANKB_DL_CHECKSUM_EN
  ,
  output logic [7:0]          dl_sum,
  output logic                dl_done
`endif
);
  localparam logic [1:0] HOLD = 2'd0, RUN = 2'd1, LOAD = 2'd2, WRITE = 2'd3;
  logic [1:0]  state_q, state_d;
  logic [7:0]  hold_q, hold_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  we_q, we_d;
  logic [13:0] addr_q, addr_d;
  logic [7:0]  din_q, din_d;
  logic        core_q, core_d;
  logic [13:0] a, off;
  logic [2:0]  we_new;
  logic        start, accept;
  assign a      = io.ioctl_addr[13:0];
  assign start  = io.ioctl_download && io.ioctl_index == 8'd0;
  assign accept = state_q == LOAD && io.ioctl_download && io.ioctl_wr &&
                  io.ioctl_addr[24:14] == 11'd0 && a <= PROM_END;
  assign we_new = a <= PROG_END ? 3'b001 : a <= GFX_END ? 3'b010 : 3'b100;
  assign off    = a <= PROG_END ? a : a <= GFX_END ? a - (PROG_END + 14'd1) : a - (GFX_END + 14'd1);
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    din_d   = din_q;
    if (state_q == HOLD) begin
      if (start) state_d = LOAD;
      else if (hold_q <= 8'd1) state_d = RUN;
      else hold_d = hold_q - 8'd1;
    end else if (state_q == RUN) begin
      if (start) state_d = LOAD;
    end else if (state_q == LOAD) begin
      if (!io.ioctl_download) begin
        state_d = HOLD;
        hold_d  = 8'(HOLD_CYCLES);
      end else if (accept) begin
        state_d = WRITE;
        cnt_d   = 4'(WR_CYCLES - 1);
        we_d    = we_new;
        addr_d  = off;
        din_d   = io.ioctl_dout;
      end
    end else if (cnt_q == 4'd0) begin
      // the byte always completes; a download fall is honoured only afterwards
      we_d    = 3'b000;
      state_d = io.ioctl_download ? LOAD : HOLD;
      hold_d  = io.ioctl_download ? hold_q : 8'(HOLD_CYCLES);
    end else begin
      cnt_d = cnt_q - 4'd1;
    end
    core_d = state_d == RUN;
  end
  always_ff @(posedge CLK_18M or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q <= HOLD;
      hold_q  <= 8'(HOLD_CYCLES);
      cnt_q   <= 4'd0;
      we_q    <= 3'b000;
      addr_q  <= 14'd0;
      din_q   <= 8'd0;
      core_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      core_q  <= core_d;
    end
  end
  assign {we_prom, we_gfx, we_prog} = we_q;
  assign io.ioctl_wait = |we_q;
  assign mem_addr      = state_q == RUN ? cpu_addr : addr_q;
  assign mem_din       = din_q;
  assign cpu_dout      = state_q == RUN ? mem_dout : 8'd0;
  assign core_reset_n  = core_q;
`ifdef TANKB_DL_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic       done_q, done_d;
  always_comb begin
    sum_d  = !state_q[1] && state_d == LOAD ? 8'd0 : accept ? sum_q + io.ioctl_dout : sum_q;
    done_d = state_q[1] && state_d == HOLD;
  end
  always_ff @(posedge CLK_18M or negedge RESET_n) begin
    if (!RESET_n) begin
      sum_q  <= 8'd0;
      done_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      done_q <= done_d;
    end
  end
  assign dl_sum  = sum_q;
  assign dl_done = done_q;
`endif
endmodule

// File: tb/tb_tankb_rom_loader.sv
// tb_tankb_rom_loader: directed self-checking bench for the ROM loader FSM, region decode and reset hold.
module tb_tankb_rom_loader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [13:0] cpu_addr = 14'd0;
  logic [7:0]  cpu_dout, mem_din, mem_dout = 8'd0;
  logic [13:0] mem_addr;
  logic        we_prog, we_gfx, we_prom, core_reset_n;
  int          n_chk = 0, n_pass = 0, n;
`ifdef TANKB_DL_CHECKSUM_EN
  logic [7:0]  dl_sum;
  logic        dl_done;
`endif
  tankb_rom_loader_if io ();
  tankb_rom_loader dut (
    .CLK_18M(clk), .RESET_n(rst_n), .io(io), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout), .we_prog(we_prog),
    .we_gfx(we_gfx), .we_prom(we_prom), .core_reset_n(core_reset_n)
`ifdef TANKB_DL_CHECKSUM_EN
    , .dl_sum(dl_sum), .dl_done(dl_done)
`endif
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic count_to_run(output int c);
    c = 0;
    while (!core_reset_n && c < 100) begin
      tick();
      c++;
    end
  endtask
  task automatic write_byte(input logic [24:0] addr, input logic [7:0] d, input logic [2:0] we_exp,
                            input logic [13:0] ma_exp, input string tag);
    io.ioctl_wr = 1'b1; io.ioctl_addr = addr; io.ioctl_dout = d;
    tick();
    io.ioctl_wr = 1'b0;
    check({tag, " we c1"}, {we_prom, we_gfx, we_prog}, we_exp);
    check({tag, " wait c1"}, io.ioctl_wait, 1);
    check({tag, " addr"}, mem_addr, ma_exp);
    check({tag, " din"}, mem_din, d);
    tick();
    check({tag, " we c2"}, {we_prom, we_gfx, we_prog}, we_exp);
    check({tag, " wait c2"}, io.ioctl_wait, 1);
    tick();
    check({tag, " we off"}, {we_prom, we_gfx, we_prog}, 0);
    check({tag, " wait off"}, io.ioctl_wait, 0);
  endtask
  task automatic bad_byte(input logic [24:0] addr, input string tag);
    io.ioctl_wr = 1'b1; io.ioctl_addr = addr; io.ioctl_dout = 8'hEE;
    tick();
    io.ioctl_wr = 1'b0;
    check({tag, " we"}, {we_prom, we_gfx, we_prog}, 0);
    check({tag, " wait"}, io.ioctl_wait, 0);
    tick();
    check({tag, " wait2"}, io.ioctl_wait, 0);
    check({tag, " core"}, core_reset_n, 0);
  endtask
  initial begin
    io.ioctl_download = 1'b0; io.ioctl_index = 8'd0; io.ioctl_wr = 1'b0;
    io.ioctl_addr = 25'd0; io.ioctl_dout = 8'd0;
    #22;
    check("rst core", core_reset_n, 0);
    check("rst we", {we_prom, we_gfx, we_prog}, 0);
    check("rst wait", io.ioctl_wait, 0);
    check("rst maddr", mem_addr, 0);
    check("rst din", mem_din, 0);
    check("rst cpu", cpu_dout, 0);
    @(negedge clk); rst_n = 1'b1;
    count_to_run(n);
    check("hold clocks", n, 16);
    cpu_addr = 14'h0123; mem_dout = 8'h5A; #1;
    check("run maddr", mem_addr, 14'h0123);
    check("run cpu", cpu_dout, 8'h5A);
    tick();
    io.ioctl_download = 1'b1; io.ioctl_index = 8'd0;
    check("core before dl", core_reset_n, 1);
    tick();
    check("core dl start", core_reset_n, 0);
    check("cpu while load", cpu_dout, 0);
    write_byte(25'h0000, 8'h11, 3'b001, 14'h0000, "prog");
    write_byte(25'h2000, 8'h22, 3'b010, 14'h0000, "gfx");
    write_byte(25'h2800, 8'h33, 3'b100, 14'h0000, "prom");
    write_byte(25'h2805, 8'h44, 3'b100, 14'h0005, "prom5");
    write_byte(25'h27FF, 8'h45, 3'b010, 14'h07FF, "gfxend");
    bad_byte(25'h2820, "oor");
    bad_byte(25'h4000, "a14");
    write_byte(25'h0010, 8'h55, 3'b001, 14'h0010, "after bad");
    io.ioctl_wr = 1'b1; io.ioctl_addr = 25'h2001; io.ioctl_dout = 8'h66;
    tick();
    io.ioctl_wr = 1'b0; io.ioctl_download = 1'b0;
    check("fall we c1", we_gfx, 1);
    tick();
    check("fall we c2", we_gfx, 1);
    check("fall maddr", mem_addr, 14'h0001);
    tick();
    check("fall we off", we_gfx, 0);
    check("fall core", core_reset_n, 0);
    count_to_run(n);
    check("fall hold", n, 16);
    io.ioctl_download = 1'b1; io.ioctl_index = 8'd1;
    tick();
    io.ioctl_wr = 1'b1; io.ioctl_addr = 25'h0000;
    tick();
    io.ioctl_wr = 1'b0;
    tick();
    check("idx1 core", core_reset_n, 1);
    check("idx1 we", {we_prom, we_gfx, we_prog}, 0);
    check("idx1 wait", io.ioctl_wait, 0);
    io.ioctl_download = 1'b0; io.ioctl_index = 8'd0;
    tick();
    io.ioctl_download = 1'b1;
    tick();
    io.ioctl_wr = 1'b1; io.ioctl_addr = 25'h0001; io.ioctl_dout = 8'h77;
    tick();
    io.ioctl_wr = 1'b0;
    check("abort pre we", we_prog, 1);
    rst_n = 1'b0;
    #1;
    check("abort we", {we_prom, we_gfx, we_prog}, 0);
    check("abort wait", io.ioctl_wait, 0);
    check("abort maddr", mem_addr, 0);
    check("abort core", core_reset_n, 0);
`ifdef TANKB_DL_CHECKSUM_EN
    check("cs rst sum", dl_sum, 0);
    io.ioctl_download = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    count_to_run(n);
    io.ioctl_download = 1'b1;
    tick();
    write_byte(25'h0000, 8'hFF, 3'b001, 14'h0000, "cs1");
    write_byte(25'h0001, 8'h02, 3'b001, 14'h0001, "cs2");
    check("cs sum", dl_sum, 8'h01);
    check("cs done idle", dl_done, 0);
    io.ioctl_download = 1'b0;
    tick();
    check("cs done", dl_done, 1);
    tick();
    check("cs done pulse", dl_done, 0);
    check("cs sum hold", dl_sum, 8'h01);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
